// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one frame per rising edge of start, LSB first,
// with a one-cycle done_flag pulse on the edge that ends the stop bit.
`timescale 1ns/1ps
module uart_tx #(
  parameter int CLK_FREQ = 4800000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       start,
  output logic       Rs232_tx_,
  output logic       done_flag
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift_reg;
  logic             start_d;
  logic             start_edge;
  logic             bit_end;

  assign start_edge = start & ~start_d;
  assign bit_end    = (cnt == CNT_LAST);

  // start_d resets high so a start held through reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      Rs232_tx_ <= 1'b1;
      done_flag <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      start_d   <= 1'b1;
    end else begin
      start_d   <= start;
      done_flag <= 1'b0;
      case (state)
        IDLE: begin
          Rs232_tx_ <= 1'b1;
          if (start_edge) begin
            shift_reg <= tx_data;
            cnt       <= '0;
            idx       <= '0;
            state     <= START;
            Rs232_tx_ <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt       <= '0;
            state     <= DATA;
            Rs232_tx_ <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              state     <= STOP;
              Rs232_tx_ <= 1'b1;
            end else begin
              idx       <= idx + 3'd1;
              Rs232_tx_ <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt       <= '0;
            state     <= IDLE;
            done_flag <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          Rs232_tx_ <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of frames plus random frames, each checked
// against a line waveform computed from the byte, plus reset sequences.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int N = 4800000 / 9600;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       start;
  logic       line;
  logic       done;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .start     (start),
    .Rs232_tx_ (line),
    .done_flag (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 none, 1 extra start pulse at act, 2 tx_data <= alt at act
  typedef struct {
    logic [7:0] data;
    logic [7:0] exp;
    logic       hold;
    int         gap;
    int         kind;
    int         act;
    logic [7:0] alt;
    int         post;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts cycles where the line is not idle-high or done_flag fires.
  task automatic idle_check(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (line !== 1'b1 || done !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  // Reference: after the start edge, cycle t carries frame bit t/N of
  // {stop, data, start}; done_flag is high only at t = 10*N.
  task automatic run_frame(input vec_t v, input string name);
    logic [9:0] fr;
    logic       exp_l;
    int         bad_line;
    int         bad_done;
    fr = {1'b1, v.exp, 1'b0};
    bad_line = 0;
    bad_done = 0;
    repeat (v.gap) @(negedge clk);
    tx_data = v.data;
    start   = 1'b1;
    for (int t = 0; t <= 10 * N; t++) begin
      @(negedge clk);
      if (t == 0 && !v.hold) start = 1'b0;
      if (v.kind == 1 && t == v.act) start = 1'b1;
      if (v.kind == 1 && t == v.act + 1) start = 1'b0;
      if (v.kind == 2 && t == v.act) tx_data = v.alt;
      exp_l = (t == 10 * N) ? 1'b1 : fr[t / N];
      if (line !== exp_l) bad_line++;
      if (done !== (t == 10 * N)) bad_done++;
    end
    check({name, "_line"}, bad_line, 0);
    check({name, "_done"}, bad_done, 0);
    if (v.hold) begin
      idle_check({name, "_held_idle"}, 20000 - 10 * N - 1);
      start = 1'b0;
    end
    if (v.post > 0) idle_check({name, "_post_idle"}, v.post);
  endtask

  initial begin
    vec_t v;
    logic [7:0] rnd;
    rst = 1'b0;
    start = 1'b1;
    tx_data = 8'h00;
    repeat (5) @(negedge clk);
    check("reset_line", int'(line), 1);
    check("reset_done", int'(done), 0);

    // start high through reset release must not launch a frame
    rst = 1'b1;
    idle_check("hold_through_reset", N);
    start = 1'b0;
    repeat (5) @(negedge clk);

    vecs[0] = '{8'h29, 8'h29, 1'b0, 2, 0, 0,    8'h00, 10};
    vecs[1] = '{8'h29, 8'h29, 1'b1, 2, 0, 0,    8'h00, 10};
    vecs[2] = '{8'h29, 8'h29, 1'b0, 2, 1, 1000, 8'h00, 2 * N};
    vecs[3] = '{8'h29, 8'h29, 1'b0, 2, 2, 2000, 8'hFF, 10};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 2, 0, 0,    8'h00, 0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 0, 0, 0,    8'h00, 10};
    for (int i = 6; i < 9; i++) begin
      rnd = 8'($urandom_range(0, 255));
      vecs[i] = '{rnd, rnd, 1'b0, int'($urandom_range(1, 20)), 2,
                  int'($urandom_range(1, 10 * N - 1)),
                  8'($urandom_range(0, 255)), 5};
    end

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // reset during data bit 3 aborts the frame
    tx_data = 8'h29;
    start = 1'b1;
    for (int t = 0; t < 4 * N + 100; t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_line", int'(line), 1);
    check("abort_done", int'(done), 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_check("post_abort_idle", 11 * N);

    v = '{8'h5A, 8'h5A, 1'b0, 2, 0, 0, 8'h00, 5};
    run_frame(v, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 4800000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL derive local constant CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide; 500 at defaults), with a counter wide enough to hold CLKS_PER_BIT-1.
REQ-004 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have tx_data  input  8  byte to transmit, sampled at frame start.
REQ-007 SHALL have start  input  1  transmit request, rising-edge triggered.
REQ-008 SHALL have Rs232_tx_  output  1  serial line, registered, idle high.
REQ-009 SHALL have done_flag  output  1  one-cycle pulse at end of frame, registered.

Function
REQ-010 SHALL register start each cycle into start_d and define start_edge = start & ~start_d.
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 In IDLE, Rs232_tx_ SHALL be 1 and done_flag 0.
REQ-013 In IDLE, on a clock edge with start_edge=1, SHALL latch tx_data into a shift register, clear the bit-timer and bit index, enter START and drive Rs232_tx_=0 from that edge.
REQ-014 START SHALL hold Rs232_tx_=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL send the 8 latched bits LSB first, bit 0 first, each held exactly CLKS_PER_BIT cycles, with a 3-bit index from 0 to 7; after bit 7 it SHALL enter STOP.
REQ-016 STOP SHALL hold Rs232_tx_=1 for exactly CLKS_PER_BIT cycles.
REQ-017 On the edge ending STOP, SHALL return to IDLE and assert done_flag=1 for exactly that one cycle.
REQ-018 A frame SHALL be 10*CLKS_PER_BIT cycles from the start-bit edge to the done_flag edge (5000 at defaults).
REQ-019 tx_data changes after latching SHALL NOT affect the frame in progress.
REQ-020 start_edge occurring outside IDLE SHALL be ignored and not queued.
REQ-021 start held high continuously SHALL produce exactly one frame; another frame requires start to go low and then high again.
REQ-022 A start_edge in the first IDLE cycle after done_flag SHALL begin a new frame with no extra idle time required.
REQ-023 Rs232_tx_ SHALL be glitch-free: it changes only at bit boundaries.

Reset
REQ-024 When rst=0 at a rising clock edge, SHALL set state=IDLE, Rs232_tx_=1, done_flag=0, bit-timer=0, bit index=0, shift register=0, and start_d=1.
REQ-025 Because start_d resets to 1, start held high through reset release SHALL NOT start a frame.
REQ-026 Reset mid-frame SHALL abort the frame: the line is high from that edge, no done_flag is produced, and no partial frame resumes after reset.
REQ-027 While rst=0, start SHALL be ignored.

Verification
REQ-028 Reset, then rst=1, tx_data=0x29, one start rising edge -> line 0,1,0,0,1,0,1,0,0,1 (start, bits 0..7, stop), each 500 cycles; done_flag high for one cycle 5000 cycles after the start-bit edge.
REQ-029 start held high for 20000 cycles with tx_data=0x29 -> exactly one frame and one done_flag pulse; line high afterward.
REQ-030 Second start edge 1000 cycles into a frame -> ignored; one frame only, data unchanged.
REQ-031 tx_data changed to 0xFF mid-frame -> the frame still carries 0x29.
REQ-032 rst=0 during DATA bit 3 -> Rs232_tx_=1 and done_flag=0 from that edge; after release the line idles high with no transmission until a new start edge.
REQ-033 Back-to-back frames 0x00 then 0xFF, with the second start edge on the cycle after done_flag -> contiguous frames; line 0 for 4500 cycles, then a 500-cycle stop, then 0 for 500 cycles and 1 for 4500 cycles.
